// File: rtl/irq_pending_arbiter_if.sv
// Request/grant bundle between event sources, the pending arbiter
// and the consumer of the encoded interrupt ID.
interface irq_pending_arbiter_if #(
   parameter int N = 4,
   parameter int W = 2
);
   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         irq_ack;
   logic         irq_valid;
   logic [W-1:0] irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   modport master (
      output req,
      output mask,
      output irq_ack,
      input  irq_valid,
      input  irq_id,
      input  pending,
      input  overrun
   );

   modport slave (
      input  req,
      input  mask,
      input  irq_ack,
      output irq_valid,
      output irq_id,
      output pending,
      output overrun
   );
endinterface

// File: rtl/irq_pending_arbiter.sv
// Edge-triggered sticky pending latch with highest-index-first
// grant presentation over a valid/ack handshake.
module irq_pending_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   irq_pending_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b01,
      PRESENT = 2'b10
   } state_t;

   state_t       r_state;
   state_t       w_next;
   logic [N-1:0] r_req_q;
   logic [N-1:0] r_pending;
   logic [N-1:0] r_overrun;
   logic [W-1:0] r_id;
   logic [N-1:0] w_edge;
   logic [N-1:0] w_clr;
   logic [W-1:0] w_sel;
   logic         w_valid;
   logic         w_grant;

   assign w_edge = bus.req & ~r_req_q & bus.mask;

   // Later iterations overwrite earlier ones, so the highest index wins.
   always_comb begin
      w_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (r_pending[k]) begin
            w_sel = W'(k);
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (r_state == PRESENT && bus.irq_ack) begin
         w_clr[r_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = IDLE;
      w_grant = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (|r_pending) begin
               w_next  = PRESENT;
               w_grant = 1'b1;
            end
         end
         PRESENT: begin
            w_next = bus.irq_ack ? IDLE : PRESENT;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_comb begin
      w_valid = 1'b0;
      unique case (r_state)
         PRESENT: w_valid = 1'b1;
         default: w_valid = 1'b0;
      endcase
   end

   // Set beats clear, and an edge racing its own clear is not an overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_req_q   <= '0;
         r_pending <= '0;
         r_overrun <= '0;
         r_id      <= '0;
      end else begin
         r_req_q   <= bus.req;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_overrun <= r_overrun | (w_edge & r_pending & ~w_clr);
         if (w_grant) begin
            r_id <= w_sel;
         end
      end
   end

   assign bus.irq_valid = w_valid;
   assign bus.irq_id    = r_id;
   assign bus.pending   = r_pending;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed-vector bench for irq_pending_arbiter.
module tb_irq_pending_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   irq_pending_arbiter_if #(.N(N), .W(W)) bus ();

   irq_pending_arbiter #(.N(N), .W(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req = 4'b0010;
      bus.mask = 4'hF;
      bus.irq_ack = 1'b0;
      tick();
      tick();
      chk("rst_pend", 32'(bus.pending), 32'h0);
      chk("rst_ovr", 32'(bus.overrun), 32'h0);
      chk("rst_vld", 32'(bus.irq_valid), 32'h0);
      chk("rst_id", 32'(bus.irq_id), 32'h0);

      rst_n = 1'b1;
      tick();
      chk("t1_pend", 32'(bus.pending), 32'h2);
      chk("t1_vld0", 32'(bus.irq_valid), 32'h0);
      tick();
      chk("t1_vld", 32'(bus.irq_valid), 32'h1);
      chk("t1_id", 32'(bus.irq_id), 32'h1);
      bus.irq_ack = 1'b1;
      tick();
      chk("t1_ackv", 32'(bus.irq_valid), 32'h0);
      chk("t1_clr", 32'(bus.pending), 32'h0);
      bus.irq_ack = 1'b0;
      bus.req = 4'b0000;
      tick();

      bus.req = 4'b0101;
      tick();
      chk("t2_pend", 32'(bus.pending), 32'h5);
      tick();
      chk("t2_vld", 32'(bus.irq_valid), 32'h1);
      chk("t2_id2", 32'(bus.irq_id), 32'h2);
      bus.irq_ack = 1'b1;
      tick();
      chk("t2_idle", 32'(bus.irq_valid), 32'h0);
      chk("t2_pend1", 32'(bus.pending), 32'h1);
      bus.irq_ack = 1'b0;
      tick();
      chk("t2_vld0", 32'(bus.irq_valid), 32'h1);
      chk("t2_id0", 32'(bus.irq_id), 32'h0);
      bus.irq_ack = 1'b1;
      tick();
      chk("t2_end", 32'(bus.pending), 32'h0);
      bus.irq_ack = 1'b0;
      bus.req = 4'b0000;
      tick();

      bus.req = 4'b0010;
      tick();
      tick();
      chk("t3_id1", 32'(bus.irq_id), 32'h1);
      bus.req = 4'b1010;
      tick();
      tick();
      tick();
      chk("t3_vld", 32'(bus.irq_valid), 32'h1);
      chk("t3_hold", 32'(bus.irq_id), 32'h1);
      chk("t3_pend", 32'(bus.pending), 32'ha);
      bus.irq_ack = 1'b1;
      tick();
      chk("t3_pend8", 32'(bus.pending), 32'h8);
      bus.irq_ack = 1'b0;
      tick();
      chk("t3_vld3", 32'(bus.irq_valid), 32'h1);
      chk("t3_id3", 32'(bus.irq_id), 32'h3);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      bus.req = 4'b0000;
      tick();
      chk("t3_end", 32'(bus.pending), 32'h0);

      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      tick();
      chk("t4_id", 32'(bus.irq_id), 32'h2);
      bus.req = 4'b0100;
      tick();
      chk("t4_ovr", 32'(bus.overrun), 32'h4);
      chk("t4_pend", 32'(bus.pending), 32'h4);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      tick();
      chk("t4_once", 32'(bus.irq_valid), 32'h0);
      chk("t4_clr", 32'(bus.pending), 32'h0);
      bus.req = 4'b0000;
      tick();

      bus.mask = 4'b1101;
      bus.req = 4'b0010;
      tick();
      chk("t5_mpend", 32'(bus.pending), 32'h0);
      tick();
      chk("t5_mvld", 32'(bus.irq_valid), 32'h0);
      bus.req = 4'b0000;
      tick();
      bus.mask = 4'hF;
      bus.req = 4'b0010;
      tick();
      chk("t5_pend", 32'(bus.pending), 32'h2);
      bus.mask = 4'b1101;
      tick();
      chk("t5_vld", 32'(bus.irq_valid), 32'h1);
      chk("t5_id", 32'(bus.irq_id), 32'h1);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      bus.req = 4'b0000;
      bus.mask = 4'hF;
      tick();

      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0000;
      tick();
      chk("t6_id0", 32'(bus.irq_id), 32'h0);
      bus.req = 4'b0001;
      bus.irq_ack = 1'b1;
      tick();
      chk("t6_pend", 32'(bus.pending), 32'h1);
      chk("t6_ovr", 32'(bus.overrun), 32'h4);
      chk("t6_idle", 32'(bus.irq_valid), 32'h0);
      bus.irq_ack = 1'b0;
      tick();
      chk("t6_vld2", 32'(bus.irq_valid), 32'h1);
      chk("t6_id2", 32'(bus.irq_id), 32'h0);
      rst_n = 1'b0;
      tick();
      chk("t6_rvld", 32'(bus.irq_valid), 32'h0);
      chk("t6_rpend", 32'(bus.pending), 32'h0);
      chk("t6_rovr", 32'(bus.overrun), 32'h0);
      chk("t6_rid", 32'(bus.irq_id), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
